// File: rtl/seq1110_moore_detector_if.sv
// Serial bit-stream link into the 1110 detector: data bit in, detect strobe and
// current FSM state out.
interface seq1110_moore_detector_if;
  logic       x;
  logic       y;
  logic [2:0] state;

  modport master (output x, input y, input state);
  modport slave  (input x, output y, output state);
endinterface

// File: rtl/seq1110_moore_detector.sv
// Moore FSM raising a one-cycle registered strobe after the serial pattern 1-1-1-0,
// with overlapping detection. The current state is exported for observation.
module seq1110_moore_detector (
  input  logic                      clk,
  input  logic                      reset,
  seq1110_moore_detector_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S1     = 3'd1,
    S11    = 3'd2,
    S111   = 3'd3,
    DETECT = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The trailing 0 of a match cannot begin a new pattern, so DETECT restarts at S1 on a 1.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.x ? S1   : IDLE;
      S1:      state_d = bus.x ? S11  : IDLE;
      S11:     state_d = bus.x ? S111 : IDLE;
      S111:    state_d = bus.x ? S111 : DETECT;
      DETECT:  state_d = bus.x ? S1   : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.y     = (state_q == DETECT);
    bus.state = state_q;
  end

endmodule

// File: tb/tb_seq1110_moore_detector.sv
// Bench for seq1110_moore_detector: a history-based reference predicts y for every
// driven bit; predictions are queued and compared after the sampling edge.
module tb_seq1110_moore_detector;

  logic clk;
  logic reset;
  seq1110_moore_detector_if bus ();

  seq1110_moore_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [0:0] exp_q[$];
  logic [3:0] hist;
  int         checks;
  int         errors;
  int         pulses;
  logic       prev_y;

  // Drive one bit away from the edge, predict y from the last four sampled bits,
  // then compare once the rising edge has sampled it.
  task automatic drive_bit(input logic b, input string name);
    logic [0:0] e;
    @(negedge clk);
    bus.x = b;
    hist  = {hist[2:0], b};
    exp_q.push_back((hist == 4'b1110) ? 1'b1 : 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, y=%0b", name, bus.y);
    end else begin
      e = exp_q.pop_front();
      if (bus.y !== e[0]) begin
        errors++;
        $display("FAIL %s: y=%0b expected %0b (state=%0d)", name, bus.y, e[0], bus.state);
      end
    end
    checks++;
    if (prev_y === 1'b1 && bus.y === 1'b1) begin
      errors++;
      $display("FAIL %s: y high on two consecutive cycles", name);
    end
    prev_y = bus.y;
    if (bus.y === 1'b1) pulses++;
  endtask

  task automatic check_pulses(input int exp_n, input string name);
    checks++;
    if (pulses !== exp_n) begin
      errors++;
      $display("FAIL %s: pulses=%0d expected %0d", name, pulses, exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hist  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.y !== 1'b0 || bus.state !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold: y=%0b state=%0d expected y=0 state=0", bus.y, bus.state);
      end
    end
    @(negedge clk);
    reset  = 1'b1;
    bus.x  = 1'b0;
    prev_y = 1'b0;
    #1;
    checks++;
    if (bus.y !== 1'b0 || bus.state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: y=%0b state=%0d expected y=0 state=0", bus.y, bus.state);
    end
  endtask

  task automatic test_basic();
    logic [4:0] s;
    s = 5'b01110;
    pulses = 0;
    for (int i = 4; i >= 0; i--) drive_bit(s[i], "basic");
    drive_bit(1'b0, "basic_drop");
    check_pulses(1, "basic_pulses");
  endtask

  task automatic test_back_to_back();
    logic [21:0] s;
    s = 22'b0111_0111_0111_1_0111_0111_0;
    pulses = 0;
    for (int i = 21; i >= 0; i--) drive_bit(s[i], "b2b");
    check_pulses(5, "b2b_pulses");
  endtask

  task automatic test_near_miss();
    logic [11:0] s;
    s = 12'b110_10_000_1110;
    pulses = 0;
    for (int i = 11; i >= 0; i--) drive_bit(s[i], "near_miss");
    drive_bit(1'b0, "near_miss_tail");
    check_pulses(1, "near_miss_pulses");
  endtask

  task automatic test_long_run();
    pulses = 0;
    for (int i = 0; i < 10; i++) drive_bit(1'b1, "long_run_ones");
    check_pulses(0, "long_run_no_early");
    drive_bit(1'b0, "long_run_zero");
    drive_bit(1'b0, "long_run_tail");
    check_pulses(1, "long_run_pulses");
  endtask

  task automatic test_async_reset();
    drive_bit(1'b1, "async_a");
    drive_bit(1'b1, "async_a");
    drive_bit(1'b1, "async_a");
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.y !== 1'b0 || bus.state !== 3'd0) begin
      errors++;
      $display("FAIL async_mid_pattern: y=%0b state=%0d expected y=0 state=0", bus.y, bus.state);
    end
    @(negedge clk);
    reset  = 1'b1;
    hist   = 4'b0000;
    prev_y = 1'b0;
    pulses = 0;
    drive_bit(1'b0, "async_after_release");
    drive_bit(1'b0, "async_after_release");
    check_pulses(0, "async_no_pulse");
    // Reset while DETECT is showing must drop y at once.
    drive_bit(1'b1, "async_b");
    drive_bit(1'b1, "async_b");
    drive_bit(1'b1, "async_b");
    drive_bit(1'b0, "async_b_detect");
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.y !== 1'b0) begin
      errors++;
      $display("FAIL async_during_detect: y=%0b expected 0", bus.y);
    end
    @(negedge clk);
    reset  = 1'b1;
    hist   = 4'b0000;
    prev_y = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) drive_bit(1'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    reset  = 1'b0;
    bus.x  = 1'b0;
    hist   = 4'b0000;
    checks = 0;
    errors = 0;
    pulses = 0;
    prev_y = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_near_miss();
    test_long_run();
    test_async_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
